load_store_unit: RTL

- Initiator side of the data memory interface. Accepts one load or store per request from the execute stage and drives the word-addressed data memory through mem_read, mem_write, mem_addr and mem_wdata. The memory returns mem_rdata combinationally in the same cycle and commits writes on the next rising clk edge.
- Converts RISC-V byte addresses and B/H/W/D widths into 64-bit word accesses. Sub-doubleword stores use read-modify-write. Loads are extracted from the correct lane and sign- or zero-extended.
- Returns the result to the pipeline on a valid/ready response channel.

---
 rtl/load_store_unit.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// ============================================================================
// load_store_unit: byte-addressed B/H/W/D loads and stores onto a 64-bit
// word memory, with read-modify-write for sub-doubleword stores.
// Revision: 1.0
// ============================================================================
`default_nettype none

module load_store_unit #(
    parameter int MEM_AW = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_data,
    output logic        resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_STORE_RD = 3'd2,
        S_STORE_WR = 3'd3,
        S_RESP     = 3'd4
    } state_t;

    state_t      state_q;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic [63:0] resp_data_q;
    logic        resp_err_q;
    logic        mem_read_q;
    logic        mem_write_q;
    logic [63:0] mem_addr_q;
    logic [63:0] mem_wdata_q;
    logic [2:0]  funct3_q;
    logic [2:0]  off_q;
    logic [63:0] wdata_q;

    logic        w_misaligned;
    logic        w_out_of_range;
    logic        w_illegal;
    logic        w_err;
    logic [63:0] w_word_idx;
    logic [63:0] w_lane;
    logic [63:0] w_load;
    logic [7:0]  w_bmask;
    logic [63:0] w_wshift;
    logic [63:0] w_merge;

    always_comb begin
        w_misaligned = 1'b0;
        case (req_funct3[1:0])
            2'd1:    w_misaligned = req_addr[0];
            2'd2:    w_misaligned = |req_addr[1:0];
            2'd3:    w_misaligned = |req_addr[2:0];
            default: w_misaligned = 1'b0;
        endcase
    end

    assign w_out_of_range = |req_addr[63:MEM_AW+3];
    assign w_illegal      = !req_is_store && (req_funct3 == 3'b111);
    assign w_err          = w_misaligned || w_out_of_range || w_illegal;
    assign w_word_idx     = {3'b000, req_addr[63:3]};

    // Load lane extraction; funct3[2] selects zero extension.
    assign w_lane = mem_rdata >> {off_q, 3'b000};

    always_comb begin
        w_load = 64'h0;
        case (funct3_q[1:0])
            2'd0:    w_load = {{56{!funct3_q[2] && w_lane[7]}},  w_lane[7:0]};
            2'd1:    w_load = {{48{!funct3_q[2] && w_lane[15]}}, w_lane[15:0]};
            2'd2:    w_load = {{32{!funct3_q[2] && w_lane[31]}}, w_lane[31:0]};
            default: w_load = w_lane;
        endcase
    end

    // Byte-lane merge of store data into the word read back from memory.
    always_comb begin
        w_bmask = 8'h00;
        case (funct3_q[1:0])
            2'd0:    w_bmask = 8'h01;
            2'd1:    w_bmask = 8'h03;
            2'd2:    w_bmask = 8'h0F;
            default: w_bmask = 8'hFF;
        endcase
        w_bmask  = w_bmask << off_q;
        w_wshift = wdata_q << {off_q, 3'b000};
        w_merge  = mem_rdata;
        for (int i = 0; i < 8; i++) begin
            if (w_bmask[i]) begin
                w_merge[8*i +: 8] = w_wshift[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 64'h0;
            resp_err_q   <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= 64'h0;
            mem_wdata_q  <= 64'h0;
            funct3_q     <= 3'b000;
            off_q        <= 3'b000;
            wdata_q      <= 64'h0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        req_ready_q <= 1'b0;
                        funct3_q    <= req_funct3;
                        off_q       <= req_addr[2:0];
                        wdata_q     <= req_wdata;
                        resp_data_q <= 64'h0;
                        resp_err_q  <= w_err;
                        if (w_err) begin
                            resp_valid_q <= 1'b1;
                            state_q      <= S_RESP;
                        end else if (!req_is_store) begin
                            mem_read_q <= 1'b1;
                            mem_addr_q <= w_word_idx;
                            state_q    <= S_LOAD;
                        end else if (req_funct3[1:0] == 2'd3) begin
                            mem_write_q <= 1'b1;
                            mem_wdata_q <= req_wdata;
                            mem_addr_q  <= w_word_idx;
                            state_q     <= S_STORE_WR;
                        end else begin
                            mem_read_q <= 1'b1;
                            mem_addr_q <= w_word_idx;
                            state_q    <= S_STORE_RD;
                        end
                    end
                end
                S_LOAD: begin
                    resp_data_q  <= w_load;
                    mem_read_q   <= 1'b0;
                    mem_addr_q   <= 64'h0;
                    resp_valid_q <= 1'b1;
                    state_q      <= S_RESP;
                end
                S_STORE_RD: begin
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b1;
                    mem_wdata_q <= w_merge;
                    state_q     <= S_STORE_WR;
                end
                S_STORE_WR: begin
                    mem_write_q  <= 1'b0;
                    mem_wdata_q  <= 64'h0;
                    mem_addr_q   <= 64'h0;
                    resp_valid_q <= 1'b1;
                    state_q      <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                    mem_read_q   <= 1'b0;
                    mem_write_q  <= 1'b0;
                    mem_addr_q   <= 64'h0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

`default_nettype wire
